// File: rtl/midi_pkg.sv
// Shared MIDI definitions: baud rate, status-byte class boundaries and the transmit FSM states.
package midi_pkg;

  localparam int unsigned MIDI_BAUD = 31250;

  localparam logic [7:0] STATUS_CH_MIN = 8'h80;
  localparam logic [7:0] STATUS_CH_MAX = 8'hEF;
  localparam logic [7:0] SYSCOM_MIN    = 8'hF0;
  localparam logic [7:0] RT_MIN        = 8'hF8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

endpackage

// File: rtl/midi_tx_fifo.sv
// Synchronous show-ahead FIFO with occupancy count and async active-high reset.
module midi_tx_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 8,
  parameter int unsigned Aw    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [Aw:0]      level_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Aw-1:0]    wptr_q, rptr_q;
  logic [Aw:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == (Aw + 1)'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (Aw + 1)'(1);
      2'b01:   level_d = level_q - (Aw + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      level_q <= level_d;
      if (push_ok) wptr_q <= wptr_q + Aw'(1);
      if (pop_ok)  rptr_q <= rptr_q + Aw'(1);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/midi_uart_tx.sv
// MIDI out serializer: FIFO-buffered 8N1 transmitter, idle-high line.
// Optional running-status compression when MIDI_TX_RUNNING_STATUS_EN is defined.
module midi_uart_tx
  import midi_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = MIDI_BAUD,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AW         = $clog2(FIFO_DEPTH)
) (
  input  logic          reg_clk,
  input  logic          reset_reg,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          midi_txd,
  output logic          busy,
  output logic [AW:0]   fifo_level,
  output logic          overflow
);

  localparam int unsigned DIV = CLK_HZ / BAUD;
  localparam int unsigned CW  = $clog2(DIV);

  tx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          txd_q;

  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic          baud_end, pop, discard;

  midi_tx_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (8),
    .Aw    (AW)
  ) u_fifo (
    .clk_i   (reg_clk),
    .rst_i   (reset_reg),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign tx_ready = ~fifo_full;
  assign overflow = tx_valid & fifo_full;
  assign busy     = (state_q != IDLE) | (fifo_level != '0);
  assign midi_txd = txd_q;

  assign baud_end = (cnt_q == CW'(DIV - 1));
  assign pop      = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & baud_end));

`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0] last_status_q, last_status_d;

  always_comb begin
    discard       = 1'b0;
    last_status_d = last_status_q;
    if (pop) begin
      if ((fifo_rdata >= STATUS_CH_MIN) && (fifo_rdata <= STATUS_CH_MAX)) begin
        if (fifo_rdata == last_status_q) discard = 1'b1;
        else last_status_d = fifo_rdata;
      end else if ((fifo_rdata >= SYSCOM_MIN) && (fifo_rdata < RT_MIN)) begin
        last_status_d = 8'h00;
      end
    end
  end

  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) last_status_q <= 8'h00;
    else           last_status_q <= last_status_d;
  end
`else
  assign discard = 1'b0;
`endif

  always_ff @(posedge reg_clk or posedge reset_reg) begin
    if (reset_reg) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pop && !discard) begin
            state_q <= START;
            shift_q <= fifo_rdata;
            txd_q   <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            state_q <= DATA;
            cnt_q   <= '0;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
          end
        end
        DATA: begin
          if (baud_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              txd_q   <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (baud_end) begin
            cnt_q <= '0;
            // Back-to-back frames: no idle gap when another byte is waiting.
            if (pop && !discard) begin
              state_q <= START;
              shift_q <= fifo_rdata;
              txd_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule
